// File: rtl/chacha_stream_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : chacha_stream_ctrl_if
// Brief    : Keystream request / byte-stream bundle between chacha_stream_ctrl
//            and its neighbours. The optional plaintext lanes exist only when
//            CHACHA_STREAM_XOR_EN is defined.
// Revision : 1.0
// ============================================================================
interface chacha_stream_ctrl_if #(
  parameter int BLOCK_BYTES = 64
);
  logic                       enable;
  logic                       ks_start;
  logic [63:0]                ks_index;
  logic                       ks_done;
  logic [8*BLOCK_BYTES-1:0]   ks_block;
  logic [7:0]                 tx_byte;
  logic                       tx_valid;
  logic                       tx_ready;
  logic                       busy;
  logic [15:0]                blocks_sent;
`ifdef CHACHA_STREAM_XOR_EN
  logic [7:0]                 pt_byte;
  logic                       pt_valid;
  logic                       pt_ready;
`endif

  // slave: the sequencer; master: whatever drives the core and UART sides
  modport slave (
    input  enable, ks_done, ks_block, tx_ready,
`ifdef CHACHA_STREAM_XOR_EN
    input  pt_byte, pt_valid,
    output pt_ready,
`endif
    output ks_start, ks_index, tx_byte, tx_valid, busy, blocks_sent
  );

  modport master (
    output enable, ks_done, ks_block, tx_ready,
`ifdef CHACHA_STREAM_XOR_EN
    output pt_byte, pt_valid,
    input  pt_ready,
`endif
    input  ks_start, ks_index, tx_byte, tx_valid, busy, blocks_sent
  );
endinterface
`default_nettype wire

// File: rtl/chacha_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : chacha_stream_ctrl
// Brief    : Requests keystream blocks from chacha20 and streams each block
//            LSB-first as bytes to the UART. Define CHACHA_STREAM_XOR_EN to
//            XOR a plaintext byte stream into the output.
// Revision : 1.0
// ============================================================================
module chacha_stream_ctrl #(
  parameter int BLOCK_BYTES = 64,
  parameter int MAX_BLOCKS  = 0
) (
  input wire                  hwclk,
  input wire                  rst_n,
  chacha_stream_ctrl_if.slave bus
);

  localparam int              BW    = 8 * BLOCK_BYTES;
  localparam int              CW    = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
  localparam logic [CW-1:0]   LAST  = CW'(BLOCK_BYTES - 1);
  localparam logic [31:0]     MAX_W = 32'(MAX_BLOCKS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_SEND = 3'd3,
    S_NEXT = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   shift_q, shift_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [63:0]     index_q, index_d;
  logic [15:0]     sent_q,  sent_d;
  logic            done_prev_q;

  logic            done_rise;
  logic [15:0]     sent_inc;
  logic            limit_now;
  logic            limit_after;
  logic            in_send;
  logic            out_valid;
  logic [7:0]      out_byte;
  logic            xfer;

  assign done_rise   = bus.ks_done & ~done_prev_q;
  assign sent_inc    = (sent_q == 16'hFFFF) ? sent_q : sent_q + 16'd1;
  assign limit_now   = (MAX_W != 32'd0) && ({16'd0, sent_q}   >= MAX_W);
  // NEXT decides on the count it is about to commit
  assign limit_after = (MAX_W != 32'd0) && ({16'd0, sent_inc} >= MAX_W);
  assign in_send     = (state_q == S_SEND);

`ifdef CHACHA_STREAM_XOR_EN
  assign out_valid    = in_send & bus.pt_valid;
  assign out_byte     = in_send ? (shift_q[7:0] ^ bus.pt_byte) : 8'h00;
  assign bus.pt_ready = in_send & bus.tx_ready;
`else
  assign out_valid    = in_send;
  assign out_byte     = in_send ? shift_q[7:0] : 8'h00;
`endif

  assign xfer            = out_valid & bus.tx_ready;
  assign bus.tx_valid    = out_valid;
  assign bus.tx_byte     = out_byte;
  assign bus.ks_start    = (state_q == S_REQ);
  assign bus.ks_index    = index_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.blocks_sent = sent_q;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    index_d = index_q;
    sent_d  = sent_q;
    case (state_q)
      S_IDLE: begin
        if (bus.enable && !limit_now) state_d = S_REQ;
      end
      S_REQ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // a level still high from the previous block has no edge and is ignored
        if (done_rise) begin
          shift_d = bus.ks_block;
          cnt_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (xfer) begin
          shift_d = shift_q >> 8;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        index_d = index_q + 64'd1;
        sent_d  = sent_inc;
        state_d = (bus.enable && !limit_after) ? S_REQ : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      index_q     <= '0;
      sent_q      <= '0;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      index_q     <= index_d;
      sent_q      <= sent_d;
      done_prev_q <= bus.ks_done;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_chacha_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_chacha_stream_ctrl
// Brief    : Scoreboard bench: a keystream-core model pushes expected bytes,
//            an independent monitor pops them on every byte transfer.
// Revision : 1.0
// ============================================================================
module tb_chacha_stream_ctrl;
  localparam int BB = 64;
  localparam int BW = 8 * BB;

  logic hwclk  = 1'b0;
  logic rst_n  = 1'b0;
  logic rst2_n = 1'b0;
  always #5 hwclk = ~hwclk;

  chacha_stream_ctrl_if #(.BLOCK_BYTES(BB)) bus  ();
  chacha_stream_ctrl_if #(.BLOCK_BYTES(BB)) bus2 ();

  chacha_stream_ctrl #(.BLOCK_BYTES(BB), .MAX_BLOCKS(0)) dut (
    .hwclk(hwclk), .rst_n(rst_n), .bus(bus.slave));
  chacha_stream_ctrl #(.BLOCK_BYTES(BB), .MAX_BLOCKS(2)) dut2 (
    .hwclk(hwclk), .rst_n(rst2_n), .bus(bus2.slave));

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  sb_q[$];
  int          cyc = 0;
  logic [63:0] exp_index;
  int          lat, lat2;
  bit          hold_done = 1'b0;
  bit          use_pattern = 1'b1;
  int          ready_mode = 0;
  int          blk_bytes = 0;
  int          t_first = 0;
  bit          burst_ok = 1'b0;
  bit          stall_pending = 1'b0;
  logic [7:0]  prev_byte;
  bit          prev_start = 1'b0;
  int          starts2 = 0;
  int          bytes2 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  function automatic logic [BW-1:0] make_block(input bit pattern);
    logic [BW-1:0] b;
    for (int i = 0; i < BB; i++) b[8*i +: 8] = pattern ? 8'(i) : 8'($urandom);
    return b;
  endfunction

  // keystream core model + UART ready driver for the main DUT
  always @(negedge hwclk) begin
    logic [BW-1:0] blk;
    cyc++;
    if (!rst_n) begin
      lat          = 0;
      bus.ks_done  = 1'b0;
      bus.ks_block = '0;
      sb_q.delete();
      exp_index    = 64'd0;
    end else if (bus.ks_start) begin
      check("ks_index_at_start", bus.ks_index, exp_index);
      exp_index++;
      if (hold_done) bus.ks_block = make_block(1'b0);
      else           bus.ks_done  = 1'b0;
      lat = $urandom_range(1, 5);
    end else if (lat > 0) begin
      lat--;
      if (lat == 0) begin
        if (bus.ks_done) begin
          bus.ks_done = 1'b0;
          lat = $urandom_range(1, 3);
        end else begin
          blk = make_block(use_pattern);
          use_pattern  = 1'b0;
          bus.ks_block = blk;
          for (int i = 0; i < BB; i++) sb_q.push_back(blk[8*i +: 8]);
          bus.ks_done = 1'b1;
        end
      end
    end
    bus.tx_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
`ifdef CHACHA_STREAM_XOR_EN
    bus.pt_valid = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    bus.pt_byte  = 8'($urandom);
`endif
  end

  // monitor for the main DUT
  always @(negedge hwclk) begin
    logic [7:0] exp;
    #1;
    if (rst_n) begin
      if (bus.ks_start) begin
        check("start_valid_exclusive", {63'd0, bus.tx_valid}, 64'd0);
        check("start_single_cycle", {63'd0, prev_start}, 64'd0);
      end
`ifdef CHACHA_STREAM_XOR_EN
      if (!bus.pt_valid) check("xor_valid_gate", {63'd0, bus.tx_valid}, 64'd0);
`else
      if (stall_pending) begin
        check("hold_valid", {63'd0, bus.tx_valid}, 64'd1);
        check("hold_byte", {56'd0, bus.tx_byte}, {56'd0, prev_byte});
      end
`endif
      if (bus.tx_valid && bus.tx_ready) begin
        if (sb_q.size() == 0) begin
          timeout("unexpected_byte");
        end else begin
          exp = sb_q.pop_front();
`ifdef CHACHA_STREAM_XOR_EN
          exp = exp ^ bus.pt_byte;
`endif
          check("tx_byte", {56'd0, bus.tx_byte}, {56'd0, exp});
        end
        if (blk_bytes == 0) begin
          t_first  = cyc;
          burst_ok = (ready_mode == 0);
        end
        if (blk_bytes == BB - 1 && burst_ok)
          check("burst_cycles", 64'(cyc - t_first), 64'(BB - 1));
        blk_bytes     = (blk_bytes + 1) % BB;
        stall_pending = 1'b0;
      end else begin
        stall_pending = bus.tx_valid;
        prev_byte     = bus.tx_byte;
      end
      prev_start = bus.ks_start;
    end else begin
      stall_pending = 1'b0;
      blk_bytes     = 0;
      prev_start    = 1'b0;
    end
  end

  // second DUT (block limit of two): fixed-pattern core, always ready
  always @(negedge hwclk) begin
    if (!rst2_n) begin
      lat2          = 0;
      bus2.ks_done  = 1'b0;
      bus2.ks_block = '0;
      for (int i = 0; i < BB; i++) bus2.ks_block[8*i +: 8] = 8'(i) ^ 8'hA5;
    end else if (bus2.ks_start) begin
      starts2++;
      bus2.ks_done = 1'b0;
      lat2 = 3;
    end else if (lat2 > 0) begin
      lat2--;
      if (lat2 == 0) bus2.ks_done = 1'b1;
    end
    bus2.tx_ready = 1'b1;
`ifdef CHACHA_STREAM_XOR_EN
    bus2.pt_valid = 1'b1;
    bus2.pt_byte  = 8'h00;
`endif
  end

  always @(negedge hwclk) begin
    #1;
    if (rst2_n && bus2.tx_valid && bus2.tx_ready) begin
      check("dut2_byte", {56'd0, bus2.tx_byte}, {56'd0, 8'(bytes2 % BB) ^ 8'hA5});
      bytes2++;
    end
  end

  task automatic wait_sent(input int n, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge hwclk); #2;
      if (int'(bus.blocks_sent) >= n) break;
    end
    if (k == budget) timeout("wait_blocks_sent");
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge hwclk); #2;
      if (blk_bytes == n) break;
    end
    if (k == budget) timeout("wait_block_bytes");
  endtask

  initial begin
    int k;
    bus.enable  = 1'b0;
    bus2.enable = 1'b0;
    repeat (3) @(negedge hwclk);
    #2;
    check("rst_ks_start", {63'd0, bus.ks_start}, 64'd0);
    check("rst_ks_index", bus.ks_index, 64'd0);
    check("rst_tx_byte", {56'd0, bus.tx_byte}, 64'd0);
    check("rst_tx_valid", {63'd0, bus.tx_valid}, 64'd0);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_blocks_sent", {48'd0, bus.blocks_sent}, 64'd0);
    rst_n  = 1'b1;
    rst2_n = 1'b1;
    @(negedge hwclk); #2;
    check("idle_busy", {63'd0, bus.busy}, 64'd0);
    bus.enable  = 1'b1;
    bus2.enable = 1'b1;
    @(negedge hwclk); #2;
    check("enable_to_start", {63'd0, bus.ks_start}, 64'd1);

    // first block: byte i = i, burst with ready held high
    wait_sent(1, 500);
    check("blk1_ks_index", bus.ks_index, 64'd1);
    check("blk1_blocks_sent", {48'd0, bus.blocks_sent}, 64'd1);

    ready_mode = 1;
    wait_sent(4, 3000);
    ready_mode = 0;
    hold_done  = 1'b1;
    wait_sent(6, 1500);
    hold_done  = 1'b0;

    // asynchronous reset in the middle of a block
    wait_bytes(10, 500);
    #1 rst_n = 1'b0;
    #1;
    check("arst_tx_valid", {63'd0, bus.tx_valid}, 64'd0);
    check("arst_ks_index", bus.ks_index, 64'd0);
    check("arst_busy", {63'd0, bus.busy}, 64'd0);
    check("arst_blocks_sent", {48'd0, bus.blocks_sent}, 64'd0);
    repeat (2) @(negedge hwclk);
    #2 rst_n = 1'b1;
    wait_sent(1, 500);
    check("restart_ks_index", bus.ks_index, 64'd1);

    // enable dropped mid-block: the block still completes
    wait_bytes(20, 500);
    bus.enable = 1'b0;
    for (k = 0; k < 500; k++) begin
      @(negedge hwclk); #2;
      if (!bus.busy) break;
    end
    if (k == 500) timeout("wait_idle");
    check("stop_blocks_sent", {48'd0, bus.blocks_sent}, 64'd2);
    check("stop_ks_index", bus.ks_index, 64'd2);
    check("stop_queue_empty", 64'(sb_q.size()), 64'd0);
    repeat (10) @(negedge hwclk);
    #2;
    check("stop_stays_idle", {63'd0, bus.busy}, 64'd0);

    // block limit instance
    check("lim_starts", 64'(starts2), 64'd2);
    check("lim_bytes", 64'(bytes2), 64'd128);
    check("lim_busy", {63'd0, bus2.busy}, 64'd0);
    check("lim_blocks_sent", {48'd0, bus2.blocks_sent}, 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
